i2c_slave_regif: RTL and testbench
==================================

I2C_SLAVE_REGIF -- requirements
Module: i2c_slave_regif

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit device address this block responds to.
REQ-002 SHALL have input clk, 1 bit, the system clock (50 MHz).
REQ-003 SHALL have input rst_n, 1 bit, an asynchronous active-low reset.
REQ-004 SHALL have input i_scl, 1 bit, the I2C clock from the bus master; it is asynchronous to clk.
REQ-005 SHALL have inout io_sda, 1 bit, the open-drain I2C data line: driven 0 when o_sda_mode=1, otherwise high-Z.
REQ-006 SHALL have output o_sda_mode, 1 bit: 1 = this block is pulling SDA low.
REQ-007 SHALL have output o_wr_en, 1 bit, a one-clk register write strobe.
REQ-008 SHALL have output o_wr_addr, 8 bits, the register write address, valid while o_wr_en=1.
REQ-009 SHALL have output o_wr_data, 8 bits, the register write data, valid while o_wr_en=1.
REQ-010 SHALL have output o_rd_addr, 8 bits, the register read address, equal to the current register pointer.
REQ-011 SHALL have input i_rd_data, 8 bits, the register read data, combinational from o_rd_addr.
REQ-012 SHALL have output o_busy, 1 bit: high from an addressed START until STOP or abandonment.

Function
REQ-013 SHALL pass i_scl and io_sda through 2-flop synchronizers plus one history flop; all edge and condition detection uses the synchronized values (2-3 clk detection latency).
REQ-014 SHALL detect START when synchronized SDA falls while synchronized SCL is high, and STOP when SDA rises while SCL is high; both are valid in any state.
REQ-015 SHALL sample SDA on each synchronized SCL rising edge, MSB first, and change its SDA drive only on synchronized SCL falling edges.
REQ-016 SHALL implement the states IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_MACK and IGNORE.
REQ-017 SHALL go from IDLE to DEV_ADDR on START, clearing the bit counter.
REQ-018 SHALL, in DEV_ADDR after 8 bits, go to DEV_ACK if bits[7:1]==SLAVE_ADDR; otherwise it SHALL go to IGNORE and never drive SDA.
REQ-019 SHALL, in any ACK state, assert o_sda_mode at the SCL falling edge after the 8th bit and deassert it at the next SCL falling edge.
REQ-020 SHALL, after DEV_ACK, go to REG_ADDR when R/W=0 and to RD_DATA when R/W=1.
REQ-021 SHALL load the register pointer with the REG_ADDR byte, ACK it, then go to WR_DATA.
REQ-022 SHALL, on the clk cycle the 8th WR_DATA bit is sampled, pulse o_wr_en for 1 clk with o_wr_addr=pointer and o_wr_data=byte, then ACK in WR_ACK.
REQ-023 SHALL increment the pointer modulo 256 after each write (0xFF wraps to 0x00) and return from WR_ACK to WR_DATA.
REQ-024 SHALL, on entering RD_DATA, capture i_rd_data into a shift register; on each SCL falling edge it SHALL drive o_sda_mode = ~bit (bit 7 first).
REQ-025 SHALL release SDA after 8 bits and sample the master's acknowledge on the next SCL rising edge in RD_MACK.
REQ-026 SHALL, on a master ACK (0), increment the pointer (wrapping) and go back to RD_DATA, reloading i_rd_data.
REQ-027 SHALL, on a master NACK (1), release SDA and go to IGNORE.
REQ-028 SHALL treat a repeated START in any state as a jump to DEV_ADDR while keeping the pointer.
REQ-029 SHALL, on STOP in any state, go to IDLE, deassert o_sda_mode and deassert o_busy.
REQ-030 SHALL give START or STOP priority over a bit sample occurring in the same clk.
REQ-031 SHALL hold IGNORE until the next START or STOP.
REQ-032 SHALL ensure o_wr_en never asserts outside WR_DATA.

Reset
REQ-033 SHALL, while rst_n=0, hold state IDLE, pointer 0x00, bit counter 0, o_sda_mode=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, and all synchronizer flops at 1.
REQ-034 SHALL, on reset mid-transfer, release SDA immediately (asynchronously), resume operation only after the next START, and emit no write strobe.

Verification
REQ-035 SHALL be covered by a write scenario: START, 0xA0, 0x12, 0x5A, STOP at 100 kHz SCL -> three ACKs, one o_wr_en pulse with addr 0x12 and data 0x5A.
REQ-036 SHALL be covered by a burst scenario: START, 0xA0, 0xFF, 0x11, 0x22, STOP -> writes (0xFF,0x11) then (0x00,0x22), showing pointer wrap.
REQ-037 SHALL be covered by an address-mismatch scenario: START, 0xA2, 0x12, STOP -> o_sda_mode stays 0 throughout and there is no o_wr_en.
REQ-038 SHALL be covered by a read scenario: START, 0xA0, 0x10, repeated START, 0xA1, master ACK, master NACK, STOP with i_rd_data = mem[addr] -> bytes mem[0x10] then mem[0x11] appear on SDA, and the block releases SDA after the NACK.
REQ-039 SHALL be covered by an abort scenario: STOP injected after bit 4 of the data byte -> return to IDLE with no o_wr_en and o_busy=0.
REQ-040 SHALL be covered by a reset scenario: rst_n asserted during an ACK -> o_sda_mode=0 within the same clk, and the next full write transaction succeeds.

Source files
------------

// File: rtl/i2c_slave_regif.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_slave_regif
//  Description : I2C slave that bridges bus transactions to a simple 8-bit
//                register file. The first byte after the device address sets
//                the register pointer. Later bytes are written with a one-clk
//                strobe, or read from i_rd_data. The pointer auto-increments
//                and wraps modulo 256.
//  Ports       : clk, rst_n    - system clock / async active-low reset
//                i_scl         - bus clock (asynchronous to clk)
//                io_sda        - open-drain bus data (driven 0 or high-Z)
//                o_sda_mode    - 1 while this block pulls SDA low
//                o_wr_en/addr/data - register write strobe and payload
//                o_rd_addr     - current register pointer
//                i_rd_data     - read data, combinational from o_rd_addr
//                o_busy        - transaction in progress for this device
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_regif #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_scl,
    inout  wire        io_sda,
    output logic       o_sda_mode,
    output logic       o_wr_en,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic [7:0] o_rd_addr,
    input  logic [7:0] i_rd_data,
    output logic       o_busy
);

    localparam logic [3:0] c_ST_IDLE     = 4'd0;
    localparam logic [3:0] c_ST_DEV_ADDR = 4'd1;
    localparam logic [3:0] c_ST_DEV_ACK  = 4'd2;
    localparam logic [3:0] c_ST_REG_ADDR = 4'd3;
    localparam logic [3:0] c_ST_REG_ACK  = 4'd4;
    localparam logic [3:0] c_ST_WR_DATA  = 4'd5;
    localparam logic [3:0] c_ST_WR_ACK   = 4'd6;
    localparam logic [3:0] c_ST_RD_DATA  = 4'd7;
    localparam logic [3:0] c_ST_RD_MACK  = 4'd8;
    localparam logic [3:0] c_ST_IGNORE   = 4'd9;

    // [0],[1] form the synchronizer, [2] is the history flop for edge detect.
    logic [2:0] r_scl_pipe_q;
    logic [2:0] r_sda_pipe_q;

    logic [3:0] r_state_q,    w_state_d;
    logic [3:0] r_bit_cnt_q,  w_bit_cnt_d;
    logic [7:0] r_shift_q,    w_shift_d;
    logic [7:0] r_ptr_q,      w_ptr_d;
    logic       r_sda_mode_q, w_sda_mode_d;

    logic       w_scl_s;
    logic       w_sda_s;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic       w_last_bit;
    logic [7:0] w_rx_byte;

    // Open-drain: only ever pull low, otherwise float.
    assign io_sda = r_sda_mode_q ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_pipe_q <= 3'b111;
            r_sda_pipe_q <= 3'b111;
        end else begin
            r_scl_pipe_q <= {r_scl_pipe_q[1:0], i_scl};
            r_sda_pipe_q <= {r_sda_pipe_q[1:0], io_sda};
        end
    end

    assign w_scl_s    = r_scl_pipe_q[1];
    assign w_sda_s    = r_sda_pipe_q[1];
    assign w_scl_rise =  w_scl_s & ~r_scl_pipe_q[2];
    assign w_scl_fall = ~w_scl_s &  r_scl_pipe_q[2];
    // SCL must be high on both samples so an SCL edge never aliases a condition.
    assign w_start    = w_scl_s & r_scl_pipe_q[2] &  r_sda_pipe_q[2] & ~w_sda_s;
    assign w_stop     = w_scl_s & r_scl_pipe_q[2] & ~r_sda_pipe_q[2] &  w_sda_s;
    assign w_last_bit = w_scl_rise && (r_bit_cnt_q == 4'd7);
    assign w_rx_byte  = {r_shift_q[6:0], w_sda_s};

    // ------------------------------------------------------------------
    // State register (plus the datapath flops that move with it). The
    // async reset drops the SDA drive immediately, mid-transfer or not.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q    <= c_ST_IDLE;
            r_bit_cnt_q  <= 4'd0;
            r_shift_q    <= 8'h00;
            r_ptr_q      <= 8'h00;
            r_sda_mode_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_bit_cnt_q  <= w_bit_cnt_d;
            r_shift_q    <= w_shift_d;
            r_ptr_q      <= w_ptr_d;
            r_sda_mode_q <= w_sda_mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. START/STOP are checked first so they win over any
    // bit event in the same clk.
    // In ACK states the bit counter marks the phase: 0 = waiting for the
    // fall that starts the ACK, 1 = waiting for the fall that ends it.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state_q;
        w_bit_cnt_d  = r_bit_cnt_q;
        w_shift_d    = r_shift_q;
        w_ptr_d      = r_ptr_q;
        w_sda_mode_d = r_sda_mode_q;

        if (w_stop) begin
            w_state_d    = c_ST_IDLE;
            w_bit_cnt_d  = 4'd0;
            w_sda_mode_d = 1'b0;
        end else if (w_start) begin
            // Covers both a fresh and a repeated START; pointer is kept.
            w_state_d    = c_ST_DEV_ADDR;
            w_bit_cnt_d  = 4'd0;
            w_sda_mode_d = 1'b0;
        end else begin
            case (r_state_q)
                c_ST_DEV_ADDR, c_ST_REG_ADDR, c_ST_WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_d   = w_rx_byte;
                        w_bit_cnt_d = r_bit_cnt_q + 4'd1;
                    end
                    if (w_last_bit) begin
                        w_bit_cnt_d = 4'd0;
                        if (r_state_q == c_ST_DEV_ADDR) begin
                            w_state_d = (w_rx_byte[7:1] == SLAVE_ADDR) ? c_ST_DEV_ACK
                                                                       : c_ST_IGNORE;
                        end else if (r_state_q == c_ST_REG_ADDR) begin
                            w_ptr_d   = w_rx_byte;
                            w_state_d = c_ST_REG_ACK;
                        end else begin
                            w_ptr_d   = r_ptr_q + 8'd1;
                            w_state_d = c_ST_WR_ACK;
                        end
                    end
                end

                c_ST_DEV_ACK, c_ST_REG_ACK, c_ST_WR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt_q == 4'd0) begin
                            w_sda_mode_d = 1'b1;
                            w_bit_cnt_d  = 4'd1;
                        end else begin
                            w_sda_mode_d = 1'b0;
                            w_bit_cnt_d  = 4'd0;
                            if (r_state_q == c_ST_DEV_ACK) begin
                                // r_shift_q still holds the address byte; bit 0 is R/W.
                                if (r_shift_q[0]) begin
                                    w_state_d    = c_ST_RD_DATA;
                                    w_shift_d    = {i_rd_data[6:0], 1'b0};
                                    w_sda_mode_d = ~i_rd_data[7];
                                end else begin
                                    w_state_d = c_ST_REG_ADDR;
                                end
                            end else begin
                                w_state_d = c_ST_WR_DATA;
                            end
                        end
                    end
                end

                c_ST_RD_DATA: begin
                    // Bit 7 was driven on entry; each fall drives the next bit.
                    if (w_scl_rise) begin
                        w_bit_cnt_d = r_bit_cnt_q + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt_q == 4'd8) begin
                            w_sda_mode_d = 1'b0;
                            w_bit_cnt_d  = 4'd0;
                            w_state_d    = c_ST_RD_MACK;
                        end else begin
                            w_sda_mode_d = ~r_shift_q[7];
                            w_shift_d    = {r_shift_q[6:0], 1'b0};
                        end
                    end
                end

                c_ST_RD_MACK: begin
                    if (w_scl_rise && (r_bit_cnt_q == 4'd0)) begin
                        if (!w_sda_s) begin
                            // Advance now so i_rd_data settles before the reload.
                            w_ptr_d     = r_ptr_q + 8'd1;
                            w_bit_cnt_d = 4'd1;
                        end else begin
                            w_sda_mode_d = 1'b0;
                            w_state_d    = c_ST_IGNORE;
                        end
                    end else if (w_scl_fall && (r_bit_cnt_q == 4'd1)) begin
                        w_state_d    = c_ST_RD_DATA;
                        w_bit_cnt_d  = 4'd0;
                        w_shift_d    = {i_rd_data[6:0], 1'b0};
                        w_sda_mode_d = ~i_rd_data[7];
                    end
                end

                c_ST_IDLE, c_ST_IGNORE: begin
                    w_sda_mode_d = 1'b0;
                end

                default: begin
                    w_state_d    = c_ST_IDLE;
                    w_bit_cnt_d  = 4'd0;
                    w_sda_mode_d = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The write strobe is combinational so it coincides with the
    // sampling of the 8th data bit and can only occur in WR_DATA; address
    // and data read as zero outside the strobe.
    // ------------------------------------------------------------------
    always_comb begin
        o_wr_en    = 1'b0;
        o_wr_addr  = 8'h00;
        o_wr_data  = 8'h00;
        o_busy     = (r_state_q != c_ST_IDLE) && (r_state_q != c_ST_IGNORE);
        o_rd_addr  = r_ptr_q;
        o_sda_mode = r_sda_mode_q;
        if ((r_state_q == c_ST_WR_DATA) && w_last_bit && !w_start && !w_stop) begin
            o_wr_en   = 1'b1;
            o_wr_addr = r_ptr_q;
            o_wr_data = w_rx_byte;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regif.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_slave_regif
//  Description : Directed bench for i2c_slave_regif. A behavioural bus master
//                drives SCL/SDA; a register array answers reads; a monitor
//                logs write strobes and counts cycles with SDA pulled low.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regif;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r_scl = 1'b1;
    logic       r_m_sda_low = 1'b0;
    wire        w_sda_bus;
    logic       w_sda_mode;
    logic       w_wr_en;
    logic [7:0] w_wr_addr;
    logic [7:0] w_wr_data;
    logic [7:0] w_rd_addr;
    logic [7:0] w_rd_data;
    logic       w_busy;

    logic [7:0] r_mem [256];
    logic [7:0] r_wr_addr_log [16];
    logic [7:0] r_wr_data_log [16];
    int         r_wr_count  = 0;
    int         r_sda_hi_cnt = 0;

    int errors = 0;
    int checks = 0;
    int tq     = 250;   // quarter SCL period in ns

    pullup (w_sda_bus);
    assign w_sda_bus = r_m_sda_low ? 1'b0 : 1'bz;
    assign w_rd_data = r_mem[w_rd_addr];

    always #10 clk = ~clk;   // 50 MHz

    i2c_slave_regif #(.SLAVE_ADDR(7'h50)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_scl      (r_scl),
        .io_sda     (w_sda_bus),
        .o_sda_mode (w_sda_mode),
        .o_wr_en    (w_wr_en),
        .o_wr_addr  (w_wr_addr),
        .o_wr_data  (w_wr_data),
        .o_rd_addr  (w_rd_addr),
        .i_rd_data  (w_rd_data),
        .o_busy     (w_busy)
    );

    always @(negedge clk) begin
        if (w_wr_en) begin
            r_wr_addr_log[r_wr_count % 16] <= w_wr_addr;
            r_wr_data_log[r_wr_count % 16] <= w_wr_data;
            r_wr_count <= r_wr_count + 1;
        end
        if (w_sda_mode) r_sda_hi_cnt <= r_sda_hi_cnt + 1;
    end

    // ---------------- bus master primitives ----------------
    task automatic send_start();
        r_m_sda_low = 1'b0; #tq; r_scl = 1'b1; #tq;
        r_m_sda_low = 1'b1; #tq; r_scl = 1'b0; #tq;
    endtask

    task automatic send_stop();
        r_m_sda_low = 1'b1; #tq; r_scl = 1'b1; #tq;
        r_m_sda_low = 1'b0; #tq;
    endtask

    task automatic send_bit(input logic b);
        r_m_sda_low = ~b; #tq; r_scl = 1'b1; #(2*tq); r_scl = 1'b0; #tq;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        r_m_sda_low = 1'b0; #tq; r_scl = 1'b1; #tq;
        ack = (w_sda_bus === 1'b0);
        #tq; r_scl = 1'b0; #tq;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            r_m_sda_low = 1'b0; #tq; r_scl = 1'b1; #tq;
            d[i] = w_sda_bus;
            #tq; r_scl = 1'b0; #tq;
        end
        send_bit(!mack);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #95;
        checks++; if (w_sda_mode !== 1'b0) begin errors++; $display("FAIL reset_sda_mode: got %b want 0", w_sda_mode); end
        checks++; if (w_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", w_wr_en); end
        checks++; if (w_wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h want 00", w_wr_addr); end
        checks++; if (w_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", w_wr_data); end
        checks++; if (w_rd_addr !== 8'h00) begin errors++; $display("FAIL reset_rd_addr: got %h want 00", w_rd_addr); end
        checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", w_busy); end
        checks++; if (w_sda_bus !== 1'b1) begin errors++; $display("FAIL reset_sda_bus: got %b want 1", w_sda_bus); end
        rst_n = 1'b1;
        #200;
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        int   base;
        tq   = 2500;   // 100 kHz SCL
        base = r_wr_count;
        send_start();
        send_byte(8'hA0, a0);
        checks++; if (w_busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", w_busy); end
        send_byte(8'h12, a1);
        send_byte(8'h5A, a2);
        send_stop();
        #1000;
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL write_acks: got %b want 111", {a0, a1, a2}); end
        checks++; if (r_wr_count - base !== 1) begin errors++; $display("FAIL write_count: got %0d want 1", r_wr_count - base); end
        checks++; if (r_wr_addr_log[base % 16] !== 8'h12) begin errors++; $display("FAIL write_addr: got %h want 12", r_wr_addr_log[base % 16]); end
        checks++; if (r_wr_data_log[base % 16] !== 8'h5A) begin errors++; $display("FAIL write_data: got %h want 5a", r_wr_data_log[base % 16]); end
        checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL write_busy_end: got %b want 0", w_busy); end
        checks++; if (w_rd_addr !== 8'h13) begin errors++; $display("FAIL write_ptr: got %h want 13", w_rd_addr); end
        tq = 250;
    endtask

    task automatic test_burst();
        logic a0, a1, a2, a3;
        int   base;
        base = r_wr_count;
        send_start();
        send_byte(8'hA0, a0);
        send_byte(8'hFF, a1);
        send_byte(8'h11, a2);
        send_byte(8'h22, a3);
        send_stop();
        #500;
        checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("FAIL burst_acks: got %b want 1111", {a0, a1, a2, a3}); end
        checks++; if (r_wr_count - base !== 2) begin errors++; $display("FAIL burst_count: got %0d want 2", r_wr_count - base); end
        checks++; if (r_wr_addr_log[base % 16] !== 8'hFF) begin errors++; $display("FAIL burst_addr0: got %h want ff", r_wr_addr_log[base % 16]); end
        checks++; if (r_wr_data_log[base % 16] !== 8'h11) begin errors++; $display("FAIL burst_data0: got %h want 11", r_wr_data_log[base % 16]); end
        checks++; if (r_wr_addr_log[(base + 1) % 16] !== 8'h00) begin errors++; $display("FAIL burst_addr1: got %h want 00", r_wr_addr_log[(base + 1) % 16]); end
        checks++; if (r_wr_data_log[(base + 1) % 16] !== 8'h22) begin errors++; $display("FAIL burst_data1: got %h want 22", r_wr_data_log[(base + 1) % 16]); end
        checks++; if (w_rd_addr !== 8'h01) begin errors++; $display("FAIL burst_ptr: got %h want 01", w_rd_addr); end
    endtask

    task automatic test_mismatch();
        logic a0, a1;
        int   base, sbase;
        base  = r_wr_count;
        sbase = r_sda_hi_cnt;
        send_start();
        send_byte(8'hA2, a0);
        checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy: got %b want 0", w_busy); end
        send_byte(8'h12, a1);
        send_stop();
        #500;
        checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL mismatch_acks: got %b want 00", {a0, a1}); end
        checks++; if (r_sda_hi_cnt - sbase !== 0) begin errors++; $display("FAIL mismatch_sda_cycles: got %0d want 0", r_sda_hi_cnt - sbase); end
        checks++; if (r_wr_count - base !== 0) begin errors++; $display("FAIL mismatch_writes: got %0d want 0", r_wr_count - base); end
        checks++; if (w_rd_addr !== 8'h01) begin errors++; $display("FAIL mismatch_ptr: got %h want 01", w_rd_addr); end
    endtask

    task automatic test_read();
        logic       a0, a1, a2;
        logic [7:0] d0, d1;
        int         base;
        base = r_wr_count;
        send_start();
        send_byte(8'hA0, a0);
        send_byte(8'h10, a1);
        send_start();
        send_byte(8'hA1, a2);
        read_byte(1'b1, d0);
        read_byte(1'b0, d1);
        #(tq / 2);
        checks++; if (w_sda_mode !== 1'b0) begin errors++; $display("FAIL read_release_mode: got %b want 0", w_sda_mode); end
        checks++; if (w_sda_bus !== 1'b1) begin errors++; $display("FAIL read_release_bus: got %b want 1", w_sda_bus); end
        send_stop();
        #500;
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL read_acks: got %b want 111", {a0, a1, a2}); end
        checks++; if (d0 !== 8'hB5) begin errors++; $display("FAIL read_byte0: got %h want b5", d0); end
        checks++; if (d1 !== 8'hB4) begin errors++; $display("FAIL read_byte1: got %h want b4", d1); end
        checks++; if (w_rd_addr !== 8'h11) begin errors++; $display("FAIL read_ptr: got %h want 11", w_rd_addr); end
        checks++; if (r_wr_count - base !== 0) begin errors++; $display("FAIL read_writes: got %0d want 0", r_wr_count - base); end
        checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL read_busy_end: got %b want 0", w_busy); end
    endtask

    task automatic test_abort();
        logic a0, a1;
        int   base;
        base = r_wr_count;
        send_start();
        send_byte(8'hA0, a0);
        send_byte(8'h20, a1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_stop();
        #500;
        checks++; if (r_wr_count - base !== 0) begin errors++; $display("FAIL abort_writes: got %0d want 0", r_wr_count - base); end
        checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", w_busy); end
        checks++; if (w_sda_mode !== 1'b0) begin errors++; $display("FAIL abort_sda_mode: got %b want 0", w_sda_mode); end
        checks++; if (w_rd_addr !== 8'h20) begin errors++; $display("FAIL abort_ptr: got %h want 20", w_rd_addr); end
    endtask

    task automatic test_reset_mid();
        logic a0, a1, a2, a3;
        int   base;
        base = r_wr_count;
        send_start();
        send_byte(8'hA0, a0);
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h30 >> i));
        r_m_sda_low = 1'b0;
        #(tq / 2);
        checks++; if (w_sda_mode !== 1'b1) begin errors++; $display("FAIL rstmid_ack_on: got %b want 1", w_sda_mode); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (w_sda_mode !== 1'b0) begin errors++; $display("FAIL rstmid_sda_mode: got %b want 0", w_sda_mode); end
        checks++; if (w_sda_bus !== 1'b1) begin errors++; $display("FAIL rstmid_sda_bus: got %b want 1", w_sda_bus); end
        #(tq / 2); r_scl = 1'b1; #(2*tq); r_scl = 1'b0; #tq;
        rst_n = 1'b1;
        #tq;
        send_stop();
        #500;
        checks++; if (r_wr_count - base !== 0) begin errors++; $display("FAIL rstmid_no_write: got %0d want 0", r_wr_count - base); end
        send_start();
        send_byte(8'hA0, a1);
        send_byte(8'h40, a2);
        send_byte(8'h77, a3);
        send_stop();
        #500;
        checks++; if ({a1, a2, a3} !== 3'b111) begin errors++; $display("FAIL rstmid_acks: got %b want 111", {a1, a2, a3}); end
        checks++; if (r_wr_count - base !== 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", r_wr_count - base); end
        checks++; if (r_wr_addr_log[base % 16] !== 8'h40) begin errors++; $display("FAIL rstmid_addr: got %h want 40", r_wr_addr_log[base % 16]); end
        checks++; if (r_wr_data_log[base % 16] !== 8'h77) begin errors++; $display("FAIL rstmid_data: got %h want 77", r_wr_data_log[base % 16]); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) r_mem[i] = 8'(i) ^ 8'hA5;
        test_reset();
        test_write();
        test_burst();
        test_mismatch();
        test_read();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
